// File: rtl/operand_accumulator.sv
// operand_accumulator: sums `count` unsigned operands of `bits` width into a
// bits+1 result with a sticky overflow flag, using valid/ready on both sides.
// Optional build macro ACC_SATURATE_EN: clamp the sum to all ones on carry-out
// instead of wrapping modulo 2^(bits+1).
// Also contains the parameterized ripple-carry adder used for every addition.

module adder #(
    parameter int unsigned Width = 9
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             carry_i,
    output logic [Width-1:0] sum_o,
    output logic             carry_o
);

    logic [Width:0] carry;

    assign carry[0] = carry_i;

    // One full-adder cell per bit, carry rippling from LSB to MSB.
    for (genvar i = 0; i < Width; i++) begin : g_fa
        assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign carry_o = carry[Width];

endmodule

module operand_accumulator #(
    parameter int unsigned bits  = 8,
    parameter int unsigned count = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [bits-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [bits:0]   out_sum,
    output logic            ovf
);

    localparam int unsigned SumW = bits + 1;
    // Wide enough for count up to 16.
    localparam int unsigned CntW = 5;
    localparam logic [CntW-1:0] CountLast = CntW'(count);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [SumW-1:0] acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic [SumW-1:0] add_sum;
    logic            add_carry;

    adder #(
        .Width (SumW)
    ) u_adder (
        .a_i     (acc_q),
        .b_i     ({1'b0, in_data}),
        .carry_i (1'b0),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = {1'b0, in_data};
                    cnt_d   = CntW'(1);
                    ovf_d   = 1'b0;
                    state_d = (count == 1) ? StDone : StAcc;
                end
            end
            StAcc: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d = cnt_q + CntW'(1);
                    ovf_d = ovf_q | add_carry;
`ifdef ACC_SATURATE_EN
                    // Once any carry has occurred the result stays pinned at all ones.
                    acc_d = (ovf_q | add_carry) ? {SumW{1'b1}} : add_sum;
`else
                    acc_d = add_sum;
`endif
                    if (cnt_d == CountLast) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_sum = acc_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_operand_accumulator.sv
// Directed, table-driven bench for operand_accumulator (bits=8, count=4).
// Build with ACC_SATURATE_EN defined to check the saturating variant.

module tb_operand_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_sum;
    logic       ovf;

    int checks;
    int failures;

    operand_accumulator #(
        .bits  (8),
        .count (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:3][7:0] ops;
        int              gap;
        int              hold;
        logic [8:0]      sum;
        logic            ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed four operands, then check the held result and its release.
    task automatic run_vec(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v.ops[i];
            chk("in_ready_acc", 32'(in_ready), 32'd1);
            chk("out_valid_early", 32'(out_valid), 32'd0);
            step();
            in_valid = 1'b0;
            in_data  = 8'hA5;
            if (i < 3) begin
                for (int g = 0; g < v.gap; g++) begin
                    chk("out_valid_gap", 32'(out_valid), 32'd0);
                    step();
                end
            end
        end
        chk("out_valid_done", 32'(out_valid), 32'd1);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        chk("out_sum", 32'(out_sum), 32'(v.sum));
        chk("ovf", 32'(ovf), 32'(v.ovf));
        out_ready = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1;
            in_data  = 8'h77;
            step();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_sum", 32'(out_sum), 32'(v.sum));
            chk("hold_ovf", 32'(ovf), 32'(v.ovf));
        end
        // Operand offered during the result transfer must be ignored.
        in_valid  = 1'b1;
        in_data   = 8'h63;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_sum", 32'(out_sum), 32'd0);
        chk("post_ovf", 32'(ovf), 32'd0);
    endtask

    vec_t vecs[6];
    vec_t v_ones;
    vec_t v_fresh;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        vecs[0] = '{ops: {8'd10, 8'd20, 8'd30, 8'd40}, gap: 0, hold: 0, sum: 9'd100, ovf: 1'b0};
`ifdef ACC_SATURATE_EN
        vecs[1] = '{ops: {8'd200, 8'd200, 8'd200, 8'd200}, gap: 0, hold: 0, sum: 9'd511, ovf: 1'b1};
        vecs[4] = '{ops: {8'd255, 8'd255, 8'd2, 8'd0}, gap: 0, hold: 1, sum: 9'd511, ovf: 1'b1};
        vecs[5] = '{ops: {8'd255, 8'd255, 8'd255, 8'd255}, gap: 1, hold: 0, sum: 9'd511, ovf: 1'b1};
`else
        vecs[1] = '{ops: {8'd200, 8'd200, 8'd200, 8'd200}, gap: 0, hold: 0, sum: 9'd288, ovf: 1'b1};
        vecs[4] = '{ops: {8'd255, 8'd255, 8'd2, 8'd0}, gap: 0, hold: 1, sum: 9'd0, ovf: 1'b1};
        vecs[5] = '{ops: {8'd255, 8'd255, 8'd255, 8'd255}, gap: 1, hold: 0, sum: 9'd508, ovf: 1'b1};
`endif
        vecs[2] = '{ops: {8'd1, 8'd2, 8'd3, 8'd4}, gap: 0, hold: 5, sum: 9'd10, ovf: 1'b0};
        vecs[3] = '{ops: {8'd5, 8'd7, 8'd9, 8'd11}, gap: 2, hold: 0, sum: 9'd32, ovf: 1'b0};
        v_ones  = '{ops: {8'd1, 8'd1, 8'd1, 8'd1}, gap: 0, hold: 0, sum: 9'd4, ovf: 1'b0};
        v_fresh = '{ops: {8'd255, 8'd255, 8'd1, 8'd0}, gap: 0, hold: 0, sum: 9'd511, ovf: 1'b0};

        // Reset state.
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
        end

        // Asynchronous reset mid-accumulation.
        in_valid = 1'b1;
        in_data  = 8'd50;
        step();
        in_data  = 8'd60;
        step();
        in_valid = 1'b0;
        chk("partial_sum", 32'(out_sum), 32'd110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_sum", 32'(out_sum), 32'd0);
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_ovf", 32'(ovf), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rel2_in_ready", 32'(in_ready), 32'd1);
        run_vec(v_ones);

        // Asynchronous reset while a result is pending.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'd9;
            step();
        end
        in_valid = 1'b0;
        chk("pend_out_valid", 32'(out_valid), 32'd1);
        chk("pend_out_sum", 32'(out_sum), 32'd36);
        #2;
        rst_n = 1'b0;
        #1;
        chk("pend_rst_out_valid", 32'(out_valid), 32'd0);
        chk("pend_rst_in_ready", 32'(in_ready), 32'd1);
        chk("pend_rst_out_sum", 32'(out_sum), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_vec(v_fresh);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
